// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor R = A - B, one bit per clock LSB first, then CVNZ flags.
// Latency: done pulses OP_SIZE+1 cycles after start is accepted; one operation per OP_SIZE+2 cycles.
// Backpressure: none; start is only honoured in IDLE, and a start seen while busy is dropped, not queued.
//
// Ports: clk, reset (sync, active-high), start, A/B operands in; busy, done pulse,
//        R difference and CCR {C,V,N,Z} out (both held until the next completion).
// Optional feature macro SERIAL_SUB_CMP_EN: adds a cmp input; when latched high, the
// operation updates CCR only and leaves R untouched (compare-only, like CMP).
module serial_sub #(
  parameter int OP_SIZE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [OP_SIZE-1:0] A,
  input  logic [OP_SIZE-1:0] B,
`ifdef SERIAL_SUB_CMP_EN
  input  logic               cmp,
`endif
  output logic               busy,
  output logic               done,
  output logic [OP_SIZE-1:0] R,
  output logic [3:0]         CCR
);

  localparam int CW = $clog2(OP_SIZE + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FLAGS} state_t;

  state_t             state_q, state_d;
  logic [OP_SIZE-1:0] a_sh_q, a_sh_d;
  logic [OP_SIZE-1:0] b_sh_q, b_sh_d;
  logic [OP_SIZE-1:0] res_q, res_d;
  logic               borrow_q, borrow_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Operand sign bits kept aside: the shift registers lose them before FLAGS.
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [OP_SIZE-1:0] r_q, r_d;
  logic [3:0]         ccr_q, ccr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               diff_bit;
  logic               ovf;
  logic               upd_r;
`ifdef SERIAL_SUB_CMP_EN
  logic               cmp_q, cmp_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    r_d      = r_q;
    ccr_d    = ccr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_bit = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
    // Signed overflow: operands of opposite sign and result sign differs from minuend.
    ovf      = (a_msb_q != b_msb_q) && (res_q[OP_SIZE-1] != a_msb_q);
`ifdef SERIAL_SUB_CMP_EN
    cmp_d    = cmp_q;
    upd_r    = ~cmp_q;
`else
    upd_r    = 1'b1;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = A;
          b_sh_d   = B;
          a_msb_d  = A[OP_SIZE-1];
          b_msb_d  = B[OP_SIZE-1];
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
`ifdef SERIAL_SUB_CMP_EN
          cmp_d    = cmp;
`endif
        end
      end
      SHIFT: begin
        borrow_d = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
        // Result fills from the MSB side so bit 0 lands at the LSB after OP_SIZE shifts.
        res_d    = {diff_bit, res_q[OP_SIZE-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(OP_SIZE - 1)) begin
          state_d = FLAGS;
        end
      end
      FLAGS: begin
        if (upd_r) begin
          r_d = res_q;
        end
        ccr_d   = {borrow_q, ovf, res_q[OP_SIZE-1], (res_q == '0)};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      r_q      <= '0;
      ccr_q    <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_CMP_EN
      cmp_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      r_q      <= r_d;
      ccr_q    <= ccr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_CMP_EN
      cmp_q    <= cmp_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign R    = r_q;
  assign CCR  = ccr_q;

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] A, B;
  logic         cmp;
  logic         busy, done;
  logic [N-1:0] R;
  logic [3:0]   CCR;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  serial_sub #(.OP_SIZE(N)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
`ifdef SERIAL_SUB_CMP_EN
    .cmp(cmp),
`endif
    .busy(busy), .done(done), .R(R), .CCR(CCR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: arithmetic difference and flag rules, plus the
  // accept / OP_SIZE+1-cycle completion timing, evaluated at each edge.
  logic [N-1:0] m_r;
  logic [3:0]   m_ccr;
  logic         m_busy, m_done;
  int           m_age;
  int           la, lb;
  bit           lcmp;

  always @(posedge clk) begin
    int diff;
    bit c, v, n, z;
    if (reset) begin
      m_r = '0; m_ccr = '0; m_busy = 0; m_done = 0; m_age = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          la = int'(A); lb = int'(B);
`ifdef SERIAL_SUB_CMP_EN
          lcmp = cmp;
`else
          lcmp = 0;
`endif
          m_busy = 1; m_age = 0;
        end
      end else begin
        m_age++;
        if (m_age == N + 1) begin
          diff = (la - lb) & ((1 << N) - 1);
          c = la < lb;
          n = diff[N-1];
          z = diff == 0;
          v = (la[N-1] != lb[N-1]) && (n != la[N-1]);
          if (!lcmp) m_r = N'(diff);
          m_ccr = {c, v, n, z};
          m_busy = 0; m_done = 1;
        end
      end
    end
  end

  // Single compare process: every cycle, #1 after the edge.
  bit cmp_en = 0;
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("R", 32'(R), 32'(m_r));
      chk("CCR", 32'(CCR), 32'(m_ccr));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
    end
  end

  // Present operands with start for one cycle (accept edge follows), then
  // count edges until done; checks latency and literal results.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit c, input logic [N-1:0] er, input logic [3:0] eccr);
    int k;
    @(negedge clk);
    A = a; B = b; cmp = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = ~a; B = ~b; cmp = 1'b0;
    k = 0;
    do begin
      @(posedge clk); #2;
      k++;
    end while (!done && k < 20);
    if (!done) begin
      chk({tag, "_timeout"}, 32'(k), 32'(N + 1));
    end else begin
      chk({tag, "_lat"}, 32'(k), 32'(N + 1));
      chk({tag, "_R"}, 32'(R), 32'(er));
      chk({tag, "_CCR"}, 32'(CCR), 32'(eccr));
    end
  endtask

  initial begin
    int k, ndone;
    reset = 1'b1; start = 1'b0; A = '0; B = '0; cmp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1;
    chk("rst_R", 32'(R), 32'h0);
    chk("rst_CCR", 32'(CCR), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(negedge clk); reset = 1'b0;

    run_op("5m3", 4'd5, 4'd3, 0, 4'd2, 4'b0000);
    run_op("3m5", 4'd3, 4'd5, 0, 4'b1110, 4'b1010);
    run_op("8m1", 4'd8, 4'd1, 0, 4'd7, 4'b0100);
    run_op("7m7", 4'd7, 4'd7, 0, 4'd0, 4'b0001);
    run_op("0m8", 4'd0, 4'd8, 0, 4'd8, 4'b1110);

    // start while busy is ignored: one done only, result of the first op
    @(negedge clk); A = 4'd5; B = 4'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); A = 4'hF; B = 4'h0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0; k = 0;
    while (k < 10) begin
      @(posedge clk); #2; k++;
      if (done) ndone++;
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_R", 32'(R), 32'd2);

    // back-to-back: start during the done cycle is accepted
    run_op("b2b_a", 4'd9, 4'd4, 0, 4'd5, 4'b0100);
    run_op("b2b_b", 4'd7, 4'd7, 0, 4'd0, 4'b0001);

    // reset mid-operation discards it
    @(negedge clk); A = 4'd3; B = 4'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #2;
    chk("mid_rst_R", 32'(R), 32'h0);
    chk("mid_rst_CCR", 32'(CCR), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    @(negedge clk); reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      if (done) ndone++;
    end
    chk("mid_rst_nodone", 32'(ndone), 32'd0);
    run_op("post_rst", 4'd5, 4'd3, 0, 4'd2, 4'b0000);

`ifdef SERIAL_SUB_CMP_EN
    run_op("cmp_base", 4'd5, 4'd3, 0, 4'd2, 4'b0000);
    run_op("cmp_only", 4'd3, 4'd5, 1, 4'd2, 4'b1010);
`endif

    repeat (3) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial subtractor computing R = A − B over OP_SIZE cycles, one bit per clock, LSB first, then producing a 4-bit CVNZ condition code register. It is the subtract counterpart to the combinational adder in the ALU datapath and uses the same CCR bit layout, so downstream flag consumers treat both units identically. A start/busy/done handshake replaces the adder's fixed-delay settling.

## Interface
Parameters:
- OP_SIZE, 4, operand and result width in bits (≥2)

Ports:
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  OP_SIZE  minuend, latched on accepted start
- B  input  OP_SIZE  subtrahend, latched on accepted start
- busy  output  1  high while in SHIFT or FLAGS
- done  output  1  one-cycle pulse; R/CCR just updated
- R  output  OP_SIZE  difference, held until next completion
- CCR  output  4  {C,V,N,Z}: bit3 C, bit2 V, bit1 N, bit0 Z; held until next completion
- cmp  input  1  present only with SERIAL_SUB_CMP_EN (see Configuration)

## Operation
- States: IDLE, SHIFT, FLAGS.
- IDLE: if start=1, latch A and B into shift registers, clear borrow, clear bit counter, go to SHIFT. Otherwise stay.
- SHIFT: each cycle, compute d = a0 ^ b0 ^ borrow and borrow' = (~a0 & b0) | (~(a0 ^ b0) & borrow). Shift d into the result register from the MSB side. Shift A and B right. Increment the counter. After OP_SIZE bits, go to FLAGS.
- FLAGS: update R from the result register and CCR as follows, then assert done and return to IDLE.
  - C = final borrow; 1 iff A < B unsigned.
  - V = (A[msb] ≠ B[msb]) & (R[msb] ≠ A[msb]), using the latched original operands.
  - N = R[msb].
  - Z = (R == 0).
- All four flags are written together. There is no partial or read-modify-write CCR update.
- start while busy=1 is ignored and is not queued.
- start in IDLE during the done-pulse cycle is accepted normally.
- A and B may change freely after the accept edge.
- Reset in any state forces IDLE and discards the operation in progress.

## Timing
- Reset values: R=0, CCR=4'b0000, busy=0, done=0, state IDLE.
- Edge 0 samples start=1 in IDLE. busy=1 from after edge 0.
- Edges 1..OP_SIZE process bits 0..OP_SIZE−1.
- Edge OP_SIZE+1 is the FLAGS cycle: R and CCR are updated, done=1, busy=0.
- done returns to 0 at edge OP_SIZE+2.
- Latency from start accept to done: OP_SIZE+1 cycles (5 for OP_SIZE=4). Throughput: one operation per OP_SIZE+2 cycles.
- R and CCR change only on a FLAGS edge or on reset, never mid-operation.

## Configuration
- SERIAL_SUB_CMP_EN defined:
  - Adds the cmp input, latched with A and B on accept.
  - If the latched cmp=1, the FLAGS cycle updates only CCR; R keeps its previous value. This is compare-only, as for a CMP instruction.
  - done and timing are unchanged.
- SERIAL_SUB_CMP_EN undefined:
  - The cmp port does not exist.
  - Every operation updates both R and CCR.

## Test plan
- After reset: R=0, CCR=0000, busy=0, done=0. Then A=5, B=3, start → done exactly 5 cycles after accept, R=2, CCR=0000.
- A=3, B=5 → R=4'b1110, CCR=1010 (C=1, N=1). A=8, B=1 → R=7, CCR=0100 (V=1).
- A=7, B=7 → R=0, CCR=0001. A=0, B=8 → R=8, CCR=1110 (C, V, N set).
- Pulse start again 2 cycles after the accept of A=5, B=3 → ignored; a single done 5 cycles after the first accept; R=2. Back-to-back start during the done cycle is accepted.
- Assert reset at cycle 3 of an operation → next cycle R=0, CCR=0000, busy=0, and no done. A new start then completes normally.
- With SERIAL_SUB_CMP_EN: run A=5, B=3 (R=2); then A=3, B=5, cmp=1 → CCR=1010 and R stays 2.
